// File: rtl/dff_pipe_pkg.sv
// ---------------------------------------------------------------------------
// dff_pipe_pkg
// Shared definitions for the dff_pipe delay line and its dff_stage cells.
//   DEFAULT_RESET_VAL : value every data stage takes on reset unless the
//                       instantiating block overrides RESET_VAL
//   clog2_plus1()     : width of a counter that must hold 0..depth inclusive
// The {valid, data} stage pair is kept as two flat vectors in the users,
// because a package-level struct cannot follow a per-instance WIDTH.
// ---------------------------------------------------------------------------
package dff_pipe_pkg;

   localparam int DEFAULT_RESET_VAL = 0;

   // A counter of stages must represent every value from empty (0) to full
   // (depth), which needs one more code than $clog2(depth) alone provides.
   function automatic int clog2_plus1(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/dff_stage.sv
// ---------------------------------------------------------------------------
// dff_stage
// One pipeline cell: a WIDTH-bit data register plus its valid bit.
// Ports:
//   clk      : clock, rising edge
//   areset   : synchronous active-high reset, loads RESET_VAL and clears valid
//   flush    : clears the valid bit only, data is left alone
//   en       : advance enable, 0 holds the cell
//   d        : data from the previous cell (or the pipe input)
//   d_valid  : valid bit from the previous cell (or the pipe input)
//   q        : registered data
//   q_valid  : registered valid bit
// ---------------------------------------------------------------------------
module dff_stage
   import dff_pipe_pkg::*;
#(
   parameter int                WIDTH     = 8,
   parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             flush,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   input  logic             d_valid,
   output logic [WIDTH-1:0] q,
   output logic             q_valid
);

   // The whole priority order of the pipe lives here so that every cell
   // behaves identically: reset wins over flush, flush wins over advance,
   // and with none of them active the cell simply holds. Flush deliberately
   // leaves the data register untouched; only the valid bit is dropped.
   always_ff @(posedge clk) begin
      if (areset) begin
         q       <= RESET_VAL;
         q_valid <= 1'b0;
      end else if (flush) begin
         q_valid <= 1'b0;
      end else if (en) begin
         q       <= d;
         q_valid <= d_valid;
      end
   end

endmodule

// File: rtl/dff_pipe.sv
// ---------------------------------------------------------------------------
// dff_pipe
// Fixed-latency WIDTH-bit delay line of DEPTH stages with per-stage valid
// tracking, stall, flush and an occupancy counter.
// Ports:
//   clk      : clock, all state updates on the rising edge
//   areset   : synchronous active-high reset
//   en       : advance enable, 0 stalls every stage and the counter
//   flush    : clears all valid bits, data registers keep their values
//   d        : data into stage 0
//   d_valid  : qualifies d
//   q        : data of the last stage (registered)
//   q_valid  : valid bit of the last stage
//   count    : number of stages currently holding valid data
// ---------------------------------------------------------------------------
module dff_pipe
   import dff_pipe_pkg::*;
#(
   parameter int                WIDTH     = 8,
   parameter int                DEPTH     = 4,
   parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
   input  logic                          clk,
   input  logic                          areset,
   input  logic                          en,
   input  logic                          flush,
   input  logic [WIDTH-1:0]              d,
   input  logic                          d_valid,
   output logic [WIDTH-1:0]              q,
   output logic                          q_valid,
   output logic [clog2_plus1(DEPTH)-1:0] count
);

   localparam int CW = clog2_plus1(DEPTH);

   logic [WIDTH-1:0] stage_data [DEPTH];
   logic [DEPTH-1:0] stage_valid;
   logic [WIDTH-1:0] link_data  [DEPTH];
   logic [DEPTH-1:0] link_valid;
   logic [CW-1:0]    count_next;

   // Stage 0 is fed from the pipe input, every later stage from the one in
   // front of it, so the chain can be built with a single instantiation.
   assign link_data[0]  = d;
   assign link_valid[0] = d_valid;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i > 0) begin : g_link
         assign link_data[i]  = stage_data[i-1];
         assign link_valid[i] = stage_valid[i-1];
      end

      dff_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clk     (clk),
         .areset  (areset),
         .flush   (flush),
         .en      (en),
         .d       (link_data[i]),
         .d_valid (link_valid[i]),
         .q       (stage_data[i]),
         .q_valid (stage_valid[i])
      );
   end

   assign q       = stage_data[DEPTH-1];
   assign q_valid = stage_valid[DEPTH-1];

   // The occupancy is tracked incrementally rather than by counting the
   // valid bits, so count comes straight from a register. On an advance one
   // word may enter and one may leave; the two cancel when both are valid,
   // which keeps the value inside 0..DEPTH without any clamping.
   always_comb begin
      count_next = count;
      if (flush) begin
         count_next = '0;
      end else if (en) begin
         count_next = count + CW'(d_valid) - CW'(stage_valid[DEPTH-1]);
      end
   end

   // Counter register; reset clears it along with every valid bit.
   always_ff @(posedge clk) begin
      if (areset) begin
         count <= '0;
      end else begin
         count <= count_next;
      end
   end

   // The running count must always agree with the valid bits it summarises.
   count_matches_valid : assert property (
      @(posedge clk) disable iff (areset)
      count == CW'($countones(stage_valid))
   );

endmodule

// File: tb/tb_dff_pipe.sv
// ---------------------------------------------------------------------------
// tb_dff_pipe
// Self-checking bench for dff_pipe. A DEPTH=4 / WIDTH=8 instance is compared
// against a queue-based reference model of the delay line; a DEPTH=1 /
// WIDTH=16 instance is checked against fixed expectations.
// ---------------------------------------------------------------------------
module tb_dff_pipe;

   localparam int W = 8;
   localparam int N = 4;

   logic         clk;
   logic         areset, en, flush, d_valid;
   logic [W-1:0] d;
   logic [W-1:0] q;
   logic         q_valid;
   logic [2:0]   count;

   logic         areset1, en1, flush1, dv1;
   logic [15:0]  d1, q1;
   logic         qv1;
   logic [0:0]   count1;

   int n_compared;
   int n_mismatched;

   // Reference model: index 0 is the word currently at the output.
   logic [W-1:0] m_data[$];
   bit           m_valid[$];

   dff_pipe #(.WIDTH(W), .DEPTH(N), .RESET_VAL(8'h00)) dut (
      .clk     (clk),
      .areset  (areset),
      .en      (en),
      .flush   (flush),
      .d       (d),
      .d_valid (d_valid),
      .q       (q),
      .q_valid (q_valid),
      .count   (count)
   );

   dff_pipe #(.WIDTH(16), .DEPTH(1), .RESET_VAL(16'h0000)) dut1 (
      .clk     (clk),
      .areset  (areset1),
      .en      (en1),
      .flush   (flush1),
      .d       (d1),
      .d_valid (dv1),
      .q       (q1),
      .q_valid (qv1),
      .count   (count1)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int m_count();
      int c = 0;
      foreach (m_valid[i]) c += int'(m_valid[i]);
      return c;
   endfunction

   // Advance the model by one rising edge with the given inputs.
   task automatic model_edge(input bit rst, input bit fl, input bit e,
                             input bit dv, input logic [W-1:0] dd);
      if (rst) begin
         foreach (m_data[i]) begin
            m_data[i]  = 8'h00;
            m_valid[i] = 1'b0;
         end
      end else if (fl) begin
         foreach (m_valid[i]) m_valid[i] = 1'b0;
      end else if (e) begin
         void'(m_data.pop_front());
         void'(m_valid.pop_front());
         m_data.push_back(dd);
         m_valid.push_back(dv);
      end
   endtask

   // Drive one cycle of inputs away from the edge, clock it, update the
   // model, and leave time 1 unit after the edge for sampling.
   task automatic applyStimulus(input bit rst, input bit fl, input bit e,
                                input bit dv, input logic [W-1:0] dd);
      @(negedge clk);
      areset = rst; flush = fl; en = e; d_valid = dv; d = dd;
      @(posedge clk);
      model_edge(rst, fl, e, dv, dd);
      #1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1, 0, 0, 0, 8'h00);
         n_compared++;
         if (q !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_q got %h want 00", q); end
         n_compared++;
         if (q_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_qv got %b want 0", q_valid); end
         n_compared++;
         if (count !== 3'd0) begin n_mismatched++; $display("[TB] FAIL reset_count got %0d want 0", count); end
      end
      applyStimulus(0, 0, 1, 1, 8'h5A);
      // Raise reset between edges: nothing may change before the next edge.
      areset = 1'b1;
      #3;
      n_compared++;
      if (count !== 3'd1) begin n_mismatched++; $display("[TB] FAIL sync_reset_early got %0d want 1", count); end
      @(posedge clk);
      model_edge(1, 0, 0, 0, 8'h00);
      #1;
      n_compared++;
      if (count !== 3'd0) begin n_mismatched++; $display("[TB] FAIL sync_reset_edge got %0d want 0", count); end
   endtask

   task automatic test_latency();
      applyStimulus(1, 0, 0, 0, 8'h00);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(0, 0, 1, 1, (k < 4) ? 8'hA1 + 8'(k) : 8'($urandom));
         n_compared++;
         if (q !== m_data[0]) begin n_mismatched++; $display("[TB] FAIL latency_q[%0d] got %h want %h", k, q, m_data[0]); end
         n_compared++;
         if (q_valid !== m_valid[0]) begin n_mismatched++; $display("[TB] FAIL latency_qv[%0d] got %b want %b", k, q_valid, m_valid[0]); end
         n_compared++;
         if (int'(count) != m_count()) begin n_mismatched++; $display("[TB] FAIL latency_count[%0d] got %0d want %0d", k, count, m_count()); end
         if (k == 3) begin
            n_compared++;
            if (q !== 8'hA1 || q_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL latency_first got %h/%b want a1/1", q, q_valid); end
         end
      end
   endtask

   task automatic test_stall();
      bit e, dv;
      logic [W-1:0] dd;
      applyStimulus(1, 0, 0, 0, 8'h00);
      // 11, 22, three stalls, 33, then idle bubbles to drain.
      for (int k = 0; k < 10; k++) begin
         e  = !(k >= 2 && k <= 4);
         dv = (k <= 1) || (k == 5);
         dd = (k == 0) ? 8'h11 : (k == 1) ? 8'h22 : (k == 5) ? 8'h33 : 8'($urandom);
         applyStimulus(0, 0, e, dv, dd);
         n_compared++;
         if (q !== m_data[0]) begin n_mismatched++; $display("[TB] FAIL stall_q[%0d] got %h want %h", k, q, m_data[0]); end
         n_compared++;
         if (q_valid !== m_valid[0]) begin n_mismatched++; $display("[TB] FAIL stall_qv[%0d] got %b want %b", k, q_valid, m_valid[0]); end
         n_compared++;
         if (int'(count) != m_count()) begin n_mismatched++; $display("[TB] FAIL stall_count[%0d] got %0d want %0d", k, count, m_count()); end
         if (k == 6) begin
            n_compared++;
            if (q !== 8'h11 || q_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL stall_first got %h/%b want 11/1", q, q_valid); end
         end
      end
   endtask

   task automatic test_bubbles();
      int peak = 0;
      applyStimulus(1, 0, 0, 0, 8'h00);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(0, 0, 1, (k < 4) ? ((k % 2) == 0) : 1'b0, 8'hC0 + 8'(k));
         if (int'(count) > peak) peak = int'(count);
         n_compared++;
         if (q !== m_data[0]) begin n_mismatched++; $display("[TB] FAIL bubble_q[%0d] got %h want %h", k, q, m_data[0]); end
         n_compared++;
         if (q_valid !== m_valid[0]) begin n_mismatched++; $display("[TB] FAIL bubble_qv[%0d] got %b want %b", k, q_valid, m_valid[0]); end
      end
      n_compared++;
      if (peak != 2) begin n_mismatched++; $display("[TB] FAIL bubble_peak got %0d want 2", peak); end
   endtask

   task automatic test_flush_priority();
      applyStimulus(1, 0, 0, 0, 8'h00);
      for (int k = 0; k < 4; k++) applyStimulus(0, 0, 1, 1, 8'h50 + 8'(k));
      applyStimulus(0, 1, 1, 1, 8'hFF);
      n_compared++;
      if (count !== 3'd0) begin n_mismatched++; $display("[TB] FAIL flush_count got %0d want 0", count); end
      n_compared++;
      if (q_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_qv got %b want 0", q_valid); end
      n_compared++;
      if (q !== 8'h50) begin n_mismatched++; $display("[TB] FAIL flush_q got %h want 50", q); end
      // FF must not have entered: drain and compare against the model.
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 0, 1, 0, 8'h00);
         n_compared++;
         if (q !== m_data[0] || q_valid !== m_valid[0]) begin n_mismatched++; $display("[TB] FAIL flush_drain[%0d] got %h/%b want %h/%b", k, q, q_valid, m_data[0], m_valid[0]); end
      end
      for (int k = 0; k < 4; k++) applyStimulus(0, 0, 1, 1, 8'h54 + 8'(k));
      applyStimulus(1, 1, 1, 1, 8'hFF);
      n_compared++;
      if (q !== 8'h00 || q_valid !== 1'b0 || count !== 3'd0) begin n_mismatched++; $display("[TB] FAIL reset_over_flush got %h/%b/%0d want 00/0/0", q, q_valid, count); end
   endtask

   task automatic test_random();
      bit rst, fl, e, dv;
      for (int k = 0; k < 300; k++) begin
         rst = ($urandom_range(31) == 0);
         fl  = ($urandom_range(15) == 0);
         e   = ($urandom_range(3) != 0);
         dv  = ($urandom_range(2) != 0);
         applyStimulus(rst, fl, e, dv, 8'($urandom));
         n_compared++;
         if (q !== m_data[0]) begin n_mismatched++; $display("[TB] FAIL rand_q[%0d] got %h want %h", k, q, m_data[0]); end
         n_compared++;
         if (q_valid !== m_valid[0]) begin n_mismatched++; $display("[TB] FAIL rand_qv[%0d] got %b want %b", k, q_valid, m_valid[0]); end
         n_compared++;
         if (int'(count) != m_count()) begin n_mismatched++; $display("[TB] FAIL rand_count[%0d] got %0d want %0d", k, count, m_count()); end
      end
   endtask

   task automatic test_depth1();
      @(negedge clk);
      areset1 = 1'b0; en1 = 1'b1; flush1 = 1'b0; dv1 = 1'b1; d1 = 16'hBEEF;
      @(posedge clk); #1;
      n_compared++;
      if (q1 !== 16'hBEEF || qv1 !== 1'b1 || count1 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL d1_capture got %h/%b/%0d want beef/1/1", q1, qv1, count1); end
      @(negedge clk);
      en1 = 1'b0; dv1 = 1'b0; d1 = 16'h1234;
      @(posedge clk); #1;
      n_compared++;
      if (q1 !== 16'hBEEF || qv1 !== 1'b1 || count1 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL d1_hold got %h/%b/%0d want beef/1/1", q1, qv1, count1); end
      @(negedge clk);
      en1 = 1'b1;
      @(posedge clk); #1;
      n_compared++;
      if (q1 !== 16'h1234 || qv1 !== 1'b0 || count1 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL d1_bubble got %h/%b/%0d want 1234/0/0", q1, qv1, count1); end
   endtask

   // Test sequence: the DEPTH=1 instance is held in reset until its turn.
   initial begin
      n_compared = 0;
      n_mismatched = 0;
      areset = 1'b1; en = 1'b0; flush = 1'b0; d_valid = 1'b0; d = '0;
      areset1 = 1'b1; en1 = 1'b0; flush1 = 1'b0; dv1 = 1'b0; d1 = '0;
      for (int i = 0; i < N; i++) begin
         m_data.push_back(8'h00);
         m_valid.push_back(1'b0);
      end
      test_reset();
      test_latency();
      test_stall();
      test_bubbles();
      test_flush_priority();
      test_random();
      test_depth1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline with per-stage valid tracking, a stall enable, a flush, and an occupancy counter.
- Used wherever the design needs a fixed-latency delay line, such as data alignment or retiming between blocks.
- Each stage is a WIDTH-bit D register plus a valid bit. Data marches one stage per enabled clock.

Parameters:
- WIDTH, 8, data bits per stage (>=1)
- DEPTH, 4, number of register stages = latency in enabled cycles (>=1)
- RESET_VAL, 0, WIDTH-bit value loaded into every data stage on reset

Ports:
- clk  input  1  clock; all state updates on rising edge
- areset  input  1  reset, synchronous, active-high; sampled on rising clk edge
- en  input  1  advance enable; 0 = stall, all stages hold
- flush  input  1  clear all valid bits (data registers untouched)
- d  input  WIDTH  data into stage 0
- d_valid  input  1  qualifies d
- q  output  WIDTH  data out of stage DEPTH-1 (registered)
- q_valid  output  1  valid bit of stage DEPTH-1
- count  output  $clog2(DEPTH+1)  number of stages currently holding valid data

Behaviour:
- Reset, synchronous: on a clk edge with areset=1:
  - every data stage takes RESET_VAL, so q=RESET_VAL;
  - every valid bit is cleared, so q_valid=0;
  - count=0.
- Reset has top priority over flush and en.
- Reset mid-stream discards all in-flight data. No output glitch before the edge.
- Priority at each edge: areset > flush > en > hold.
- Flush (areset=0, flush=1):
  - all valid bits are cleared and count becomes 0;
  - data registers keep their values;
  - d/d_valid presented in the same cycle are dropped, regardless of en.
- Advance (areset=0, flush=0, en=1):
  - stage[0] <= {d_valid, d};
  - stage[i] <= stage[i-1] for 1 <= i < DEPTH;
  - the old stage[DEPTH-1] is discarded.
  - d is captured even when d_valid=0, with its valid bit stored as 0.
- Stall (en=0, flush=0, areset=0): every stage and count hold their value exactly.
- Latency: a word presented with en=1 at edge k appears on q/q_valid after edge k+DEPTH-1. That is DEPTH enabled edges counting the capture edge. Stalled cycles add 1:1.
- DEPTH=1 degenerates to a plain enabled D register with a valid bit. Its latency is one edge.
- count maintenance:
  - count is a registered running count;
  - on advance, count_next = count + d_valid - old stage[DEPTH-1].valid;
  - count never exceeds DEPTH and never underflows. Assertion: count equals popcount of the valid bits every cycle.
- Bubbles (d_valid=0) propagate as invalid stages; q still shows the stage data.
- All outputs are direct register outputs. There is no combinational path from any input to any output.

Decomposition:
- Shared package dff_pipe_pkg holds:
  - the counter-width function clog2_plus1(DEPTH);
  - the default RESET_VAL constant;
  - a stage struct typedef {valid, data} parametrised through WIDTH at instantiation, or a localparam-based pair of flat vectors.
- Natural sub-module: dff_stage. It is one WIDTH-bit register plus a valid bit with areset/flush/en inputs, and it encodes the priority rules once.
- dff_pipe generates DEPTH instances of dff_stage and adds the count register.

Test Plan:
1. Reset then idle: WIDTH=8, DEPTH=4, RESET_VAL=8'h00. Hold areset=1 for 2 edges, then 0 -> q=8'h00, q_valid=0, count=0. Check that areset asserted between edges has no effect until the next rising edge, proving it is synchronous.
2. Latency: en=1, drive d=8'hA1,A2,A3,A4 with d_valid=1 on consecutive edges -> q=8'hA1, q_valid=1 after the 4th edge, then A2, A3, A4 on the following edges. count goes 1,2,3,4 and stays 4 while the stream continues.
3. Stall: stream 8'h11,22,33. Hold en=0 for 3 edges after 8'h22 is captured -> q, q_valid and count frozen. Output order is preserved with latency extended by exactly 3.
4. Bubbles: d_valid pattern 1,0,1,0 with d=8'hC0..C3 -> q_valid pattern 1,0,1,0 starting after the 4th edge. count peaks at 2.
5. Flush vs reset priority: pipe full of valid 8'h5x. Assert flush=1 with en=1, d=8'hFF, d_valid=1 for one edge -> count=0, q_valid=0, q still holds the old 8'h5x, 8'hFF is dropped. Repeat with areset=1 and flush=1 together -> q=RESET_VAL.
6. DEPTH=1, WIDTH=16: d=16'hBEEF, d_valid=1 -> q=16'hBEEF, q_valid=1, count=1 after one edge. With en=0 and d changed, q is held.
